// File: rtl/svm_mem_sequencer.sv
`timescale 1ns/1ps
// Memory command sequencer: SRAM burst reads into compute-array lanes, result-word writes, batch pointers.
// Response is a held level, raised with the last array write; SRAM grant and read latency (>=1) throttle bursts.
module svm_mem_sequencer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    LANES      = 32,
    parameter logic [ADDR_WIDTH-1:0] WGHT_BASE  = 16'h0000,
    parameter logic [ADDR_WIDTH-1:0] DATA_BASE  = 16'h1000,
    parameter logic [ADDR_WIDTH-1:0] RES_BASE   = 16'h8000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_done,
    input  logic                     mem_cmd_vld,
    input  logic [3:0]               mem_cmd,
    input  logic [DATA_WIDTH-1:0]    mem_cmd_data,
    output logic                     mem_resp_vld,
    output logic [2:0]               mem_resp,
    output logic [DATA_WIDTH-1:0]    mem_resp_data,
    output logic                     sram_req,
    input  logic                     sram_gnt,
    output logic                     sram_we,
    output logic [ADDR_WIDTH-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0]    sram_wdata,
    input  logic [DATA_WIDTH-1:0]    sram_rdata,
    input  logic                     sram_rvld,
    output logic                     arr_wr_vld,
    output logic [$clog2(LANES)-1:0] arr_wr_idx,
    output logic [DATA_WIDTH-1:0]    arr_wr_data,
    output logic                     arr_wghtbar_data,
    output logic [1:0]               err
);
    localparam int IDX_W = $clog2(LANES);
    localparam int CNT_W = $clog2(LANES + 1);

    localparam logic [3:0] CMD_LW = 4'd0;
    localparam logic [3:0] CMD_LD = 4'd1;
    localparam logic [3:0] CMD_WR = 4'd3;

    typedef enum logic [1:0] {IDLE, RD, WR_RES, DONE} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             cmd_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [CNT_W-1:0]       n_q, issued, returned, n_req;
    logic [ADDR_WIDTH-1:0]  wght_ptr, data_ptr, res_ptr, base_ptr;
    logic [DATA_WIDTH-1:0]  resp_data_q;
    logic [1:0]             err_q, err_nxt;
    logic                   arr_vld_q, wghtbar_q;
    logic [IDX_W-1:0]       arr_idx_q;
    logic [DATA_WIDTH-1:0]  arr_data_q;
    logic [2:0]             resp_code;
    logic                   accept, cfg_load, is_load, bad_cmd;
    logic                   rd_gnt, wr_gnt, rvld_ok, last_ret;

    // Zero stays zero through the truncation; anything past LANES clamps.
    assign n_req    = (mem_cmd_data > DATA_WIDTH'(LANES)) ? CNT_W'(LANES) : mem_cmd_data[CNT_W-1:0];
    assign is_load  = (mem_cmd == CMD_LW) || (mem_cmd == CMD_LD);
    assign bad_cmd  = accept && !is_load && (mem_cmd != CMD_WR);
    assign base_ptr = (cmd_q == CMD_LD) ? data_ptr : wght_ptr;
    assign rd_gnt   = (state == RD) && sram_req && sram_gnt;
    assign wr_gnt   = (state == WR_RES) && sram_gnt;
    assign rvld_ok  = (state == RD) && sram_rvld && (returned != issued);
    assign last_ret = rvld_ok && ((returned + CNT_W'(1)) == n_q);

    always_comb begin
        state_nxt  = state;
        sram_req   = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        accept     = 1'b0;
        cfg_load   = 1'b0;
        resp_code  = 3'd0;
        err_nxt    = err_q;
        case (state)
            IDLE: begin
                if (cfg_done) begin
                    cfg_load = 1'b1;
                end else if (mem_cmd_vld) begin
                    accept = 1'b1;
                    if (is_load)
                        state_nxt = (n_req == '0) ? DONE : RD;
                    else if (mem_cmd == CMD_WR)
                        state_nxt = WR_RES;
                end
            end
            RD: begin
                if (issued < n_q) begin
                    sram_req  = 1'b1;
                    sram_addr = base_ptr + ADDR_WIDTH'(issued);
                end
                if (last_ret)
                    state_nxt = DONE;
            end
            WR_RES: begin
                sram_req   = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = res_ptr;
                sram_wdata = data_q;
                if (sram_gnt)
                    state_nxt = DONE;
            end
            DONE: begin
                if (!mem_cmd_vld || (mem_cmd != cmd_q))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (cmd_q == CMD_LD)
            resp_code = 3'd1;
        else if (cmd_q == CMD_WR)
            resp_code = 3'd2;
        if (cfg_load)
            err_nxt = 2'b00;
        if (bad_cmd)
            err_nxt[0] = 1'b1;
        if (sram_rvld && !rvld_ok)
            err_nxt[1] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_q       <= '0;
            data_q      <= '0;
            n_q         <= '0;
            issued      <= '0;
            returned    <= '0;
            wght_ptr    <= WGHT_BASE;
            data_ptr    <= DATA_BASE;
            res_ptr     <= RES_BASE;
            resp_data_q <= '0;
            err_q       <= '0;
            arr_vld_q   <= 1'b0;
            arr_idx_q   <= '0;
            arr_data_q  <= '0;
            wghtbar_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            err_q     <= err_nxt;
            arr_vld_q <= rvld_ok;
            if (cfg_load) begin
                wght_ptr <= WGHT_BASE;
                data_ptr <= DATA_BASE;
                res_ptr  <= RES_BASE;
            end
            if (accept) begin
                cmd_q       <= mem_cmd;
                data_q      <= mem_cmd_data;
                n_q         <= n_req;
                issued      <= '0;
                returned    <= '0;
                resp_data_q <= DATA_WIDTH'(n_req);
                if (is_load && (n_req != '0))
                    wghtbar_q <= (mem_cmd == CMD_LD);
            end
            if (rd_gnt)
                issued <= issued + CNT_W'(1);
            if (rvld_ok) begin
                arr_idx_q  <= returned[IDX_W-1:0];
                arr_data_q <= sram_rdata;
                returned   <= returned + CNT_W'(1);
            end
            // Pointer moves on the same edge that registers the final lane write.
            if (last_ret) begin
                if (cmd_q == CMD_LD)
                    data_ptr <= data_ptr + ADDR_WIDTH'(n_q);
                else
                    wght_ptr <= wght_ptr + ADDR_WIDTH'(n_q);
            end
            // Each data point reuses the same weight set, so rewind the weight pointer.
            if (wr_gnt) begin
                resp_data_q <= DATA_WIDTH'(res_ptr);
                res_ptr     <= res_ptr + ADDR_WIDTH'(1);
                wght_ptr    <= WGHT_BASE;
            end
        end
    end

    assign mem_resp_vld     = (state == DONE);
    assign mem_resp         = (state == DONE) ? resp_code : 3'd0;
    assign mem_resp_data    = (state == DONE) ? resp_data_q : '0;
    assign arr_wr_vld       = arr_vld_q;
    assign arr_wr_idx       = arr_idx_q;
    assign arr_wr_data      = arr_data_q;
    assign arr_wghtbar_data = wghtbar_q;
    assign err              = err_q;

endmodule

// File: tb/tb_svm_mem_sequencer.sv
`timescale 1ns/1ps
// Bench for svm_mem_sequencer: directed vector table, multi-cycle corner sequences, then
// randomized commands checked against a pointer-level reference model with an SRAM responder.
module tb_svm_mem_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, cfg_done, mem_cmd_vld;
    logic [3:0]  mem_cmd;
    logic [31:0] mem_cmd_data;
    logic        mem_resp_vld;
    logic [2:0]  mem_resp;
    logic [31:0] mem_resp_data;
    logic        sram_req, sram_gnt, sram_we, sram_rvld;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic        arr_wr_vld, arr_wghtbar_data;
    logic [4:0]  arr_wr_idx;
    logic [31:0] arr_wr_data;
    logic [1:0]  err;

    svm_mem_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cfg_done(cfg_done),
        .mem_cmd_vld(mem_cmd_vld), .mem_cmd(mem_cmd), .mem_cmd_data(mem_cmd_data),
        .mem_resp_vld(mem_resp_vld), .mem_resp(mem_resp), .mem_resp_data(mem_resp_data),
        .sram_req(sram_req), .sram_gnt(sram_gnt), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_rvld(sram_rvld),
        .arr_wr_vld(arr_wr_vld), .arr_wr_idx(arr_wr_idx), .arr_wr_data(arr_wr_data),
        .arr_wghtbar_data(arr_wghtbar_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic wb; logic [4:0] idx; logic [31:0] dat; } arr_t;
    typedef struct packed { logic [15:0] addr; logic [31:0] dat; } wr_t;
    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] data;
        int          gm;
        int          lat;
        logic [2:0]  e_resp;
        logic [31:0] e_rdata;
        logic [15:0] e_addr;
        int          e_cnt;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] rd_q[$];
    wr_t         wr_q[$];
    arr_t        arr_q[$];
    logic [15:0] pend_a[$];
    int          pend_t[$];
    int          gnt_mode, rd_lat, cyc_n, wait_cnt;
    bit          force_rvld, toggle;
    logic [15:0] m_w, m_d, m_r;
    logic [126:0] outs_vec;

    assign outs_vec = {sram_req, sram_we, sram_addr, sram_wdata, arr_wr_vld, arr_wr_idx, arr_wr_data,
                       arr_wghtbar_data, mem_resp_vld, mem_resp, mem_resp_data, err};

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hC3A5, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // SRAM responder: grant policy, in-order read returns after rd_lat cycles, access logging.
    always @(negedge clk) begin
        bit g;
        cyc_n++;
        g = 1'b0;
        if (!rst_n) begin
            pend_a.delete();
            pend_t.delete();
            sram_rvld = 1'b0;
            sram_gnt  = 1'b0;
            wait_cnt  = 0;
        end else begin
            if (pend_t.size() > 0 && pend_t[0] <= cyc_n) begin
                sram_rvld  = 1'b1;
                sram_rdata = mem_word(pend_a[0]);
                void'(pend_a.pop_front());
                void'(pend_t.pop_front());
            end else begin
                sram_rvld  = force_rvld;
                sram_rdata = 32'hDEAD_BEEF;
            end
            case (gnt_mode)
                0: g = 1'b1;
                1: begin g = toggle; toggle = ~toggle; end
                2: g = ($urandom_range(0, 1) == 1);
                default: begin
                    if (sram_req) begin
                        g = (wait_cnt >= 3);
                        wait_cnt = g ? 0 : wait_cnt + 1;
                    end
                end
            endcase
            sram_gnt = g;
            if (sram_req && g) begin
                if (sram_we) begin
                    wr_q.push_back('{addr: sram_addr, dat: sram_wdata});
                end else begin
                    rd_q.push_back(sram_addr);
                    pend_a.push_back(sram_addr);
                    pend_t.push_back(cyc_n + rd_lat);
                end
            end
        end
        if (arr_wr_vld)
            arr_q.push_back('{wb: arr_wghtbar_data, idx: arr_wr_idx, dat: arr_wr_data});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wr_q.delete();
        arr_q.delete();
    endtask

    task automatic pulse_cfg();
        mem_cmd_vld = 1'b0;
        step();
        cfg_done = 1'b1;
        step();
        cfg_done = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] c, input logic [31:0] d, input int gm, input int lat,
                           input logic [2:0] e_resp, input logic [31:0] e_rdata,
                           input logic [15:0] e_addr, input int e_cnt);
        int cyc;
        if (mem_cmd_vld && mem_cmd == c) begin
            mem_cmd_vld = 1'b0;
            step();
        end
        gnt_mode = gm;
        rd_lat   = lat;
        clear_logs();
        mem_cmd_vld  = 1'b1;
        mem_cmd      = c;
        mem_cmd_data = d;
        cyc = 0;
        while (mem_resp_vld && cyc < 10) begin step(); cyc++; end
        cyc = 0;
        while (!mem_resp_vld && cyc < 1000) begin step(); cyc++; end
        chk("resp_seen", 128'(mem_resp_vld), 128'(1));
        if (c != 4'd3 && e_cnt == 0)
            chk("zero_len_latency_le2", 128'(cyc <= 2), 128'(1));
        if (c != 4'd3 && e_cnt > 0)
            chk("last_arr_wr_in_first_done", 128'({arr_wr_vld, arr_wr_idx}), 128'({1'b1, 5'(e_cnt - 1)}));
        chk("resp_code", 128'(mem_resp), 128'(e_resp));
        chk("resp_data", 128'(mem_resp_data), 128'(e_rdata));
        @(negedge clk);
        #1;
        if (c == 4'd3) begin
            chk("wr_count", 128'(wr_q.size()), 128'(1));
            chk("wr_no_reads", 128'(rd_q.size()), 128'(0));
            chk("wr_no_arr", 128'(arr_q.size()), 128'(0));
            if (wr_q.size() == 1)
                chk("wr_addr_data", 128'(wr_q[0]), 128'({e_addr, d}));
        end else begin
            chk("rd_count", 128'(rd_q.size()), 128'(e_cnt));
            chk("arr_count", 128'(arr_q.size()), 128'(e_cnt));
            chk("no_writes", 128'(wr_q.size()), 128'(0));
            if (rd_q.size() == e_cnt && arr_q.size() == e_cnt) begin
                for (int i = 0; i < e_cnt; i++) begin
                    chk("rd_addr", 128'(rd_q[i]), 128'(e_addr + 16'(i)));
                    chk("arr_write", 128'(arr_q[i]),
                        128'({c == 4'd1, 5'(i), mem_word(e_addr + 16'(i))}));
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk("resp_held", 128'({mem_resp_vld, mem_resp, mem_resp_data}), 128'({1'b1, e_resp, e_rdata}));
        end
    endtask

    vec_t tbl[9];

    initial begin
        bit saw;
        int cyc;
        logic [3:0]  c;
        logic [31:0] d;
        logic [31:0] n;
        logic [2:0]  er;
        logic [31:0] ed;
        logic [15:0] ea;
        int          r;

        tbl[0] = '{4'd0, 32'd32,      0, 2, 3'd0, 32'd32,     16'h0000, 32};
        tbl[1] = '{4'd1, 32'd7,       1, 1, 3'd1, 32'd7,      16'h1000, 7};
        tbl[2] = '{4'd1, 32'd7,       0, 3, 3'd1, 32'd7,      16'h1007, 7};
        tbl[3] = '{4'd3, 32'd1,       3, 1, 3'd2, 32'h8000,   16'h8000, 1};
        tbl[4] = '{4'd0, 32'd0,       0, 1, 3'd0, 32'd0,      16'h0000, 0};
        tbl[5] = '{4'd0, 32'd40,      2, 2, 3'd0, 32'd32,     16'h0000, 32};
        tbl[6] = '{4'd0, 32'd5,       2, 4, 3'd0, 32'd5,      16'h0020, 5};
        tbl[7] = '{4'd3, 32'hCAFE,    0, 1, 3'd2, 32'h8001,   16'h8001, 1};
        tbl[8] = '{4'd1, 32'd33,      3, 1, 3'd1, 32'd32,     16'h100E, 32};

        rst_n = 1'b0; cfg_done = 1'b0; mem_cmd_vld = 1'b0; mem_cmd = '0; mem_cmd_data = '0;
        gnt_mode = 0; rd_lat = 1; force_rvld = 1'b0; toggle = 1'b0; cyc_n = 0; wait_cnt = 0;
        sram_gnt = 1'b0; sram_rvld = 1'b0; sram_rdata = '0;
        repeat (3) step();
        chk("reset_outputs_zero", {1'b0, outs_vec}, 128'(0));
        rst_n = 1'b1;
        step();
        chk("idle_outputs_zero", {1'b0, outs_vec}, 128'(0));

        pulse_cfg();
        foreach (tbl[i])
            run_cmd(tbl[i].cmd, tbl[i].data, tbl[i].gm, tbl[i].lat,
                    tbl[i].e_resp, tbl[i].e_rdata, tbl[i].e_addr, tbl[i].e_cnt);

        // Unsupported command, stray read data, then cfg_done clearing both flags.
        mem_cmd_vld = 1'b0;
        step();
        clear_logs();
        mem_cmd = 4'd2; mem_cmd_data = 32'd4; mem_cmd_vld = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (mem_resp_vld || sram_req) saw = 1'b1;
        end
        chk("badcmd_err0", 128'(err), 128'(2'b01));
        chk("badcmd_no_activity", 128'(saw), 128'(0));
        mem_cmd_vld = 1'b0;
        force_rvld = 1'b1;
        step();
        force_rvld = 1'b0;
        step();
        chk("stray_rvld_err1", 128'(err), 128'(2'b11));
        cfg_done = 1'b1;
        step();
        cfg_done = 1'b0;
        chk("cfg_clears_err", 128'(err), 128'(0));

        // Reset in the middle of a 32-word weight load.
        gnt_mode = 0; rd_lat = 2;
        clear_logs();
        mem_cmd = 4'd0; mem_cmd_data = 32'd32; mem_cmd_vld = 1'b1;
        cyc = 0;
        while (arr_q.size() < 5 && cyc < 200) begin step(); cyc++; end
        chk("mid_rd_progress", 128'(arr_q.size() >= 5), 128'(1));
        chk("mid_rd_busy", 128'(sram_req | arr_wr_vld), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {1'b0, outs_vec}, 128'(0));
        mem_cmd_vld = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        run_cmd(4'd0, 32'd4, 0, 2, 3'd0, 32'd4, 16'h0000, 4);

        // Randomized commands against the pointer-level model.
        pulse_cfg();
        m_w = 16'h0000; m_d = 16'h1000; m_r = 16'h8000;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            c = (r < 4) ? 4'd0 : (r < 8) ? 4'd1 : 4'd3;
            d = (c == 4'd3) ? $urandom : 32'($urandom_range(0, 45));
            if (c == 4'd3) begin
                er = 3'd2; ed = 32'(m_r); ea = m_r; n = 1;
                m_r = m_r + 16'd1;
                m_w = 16'h0000;
            end else begin
                n  = (d > 32) ? 32'd32 : d;
                er = 3'(c);
                ed = n;
                ea = (c == 4'd0) ? m_w : m_d;
                if (c == 4'd0) m_w = m_w + 16'(n);
                else           m_d = m_d + 16'(n);
            end
            run_cmd(c, d, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), er, ed, ea, int'(n));
        end

        mem_cmd_vld = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/svm_mem_sequencer.md
Name: svm_mem_sequencer

Overview:
- Services the inference FSM's memory command channel (mem_cmd_vld/mem_cmd/mem_cmd_data → mem_resp/mem_resp_vld).
- LOAD_WEIGHTS and LOAD_DATA: reads N words from a single-port SRAM and streams them into the compute array, indexed by lane.
- WR_INFER_RES: writes the class word to the result region.
- Tracks weight, data-vector and result pointers across a batch, and holds each response until the requester drops or changes its command.

Parameters:
- DATA_WIDTH, 32, width of SRAM, array and command data words.
- ADDR_WIDTH, 16, SRAM word-address width.
- LANES, 32, maximum words per load; also the array depth.
- WGHT_BASE, 16'h0000, first weight word address.
- DATA_BASE, 16'h1000, first data-vector word address.
- RES_BASE, 16'h8000, first inference-result word address.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_done  in  1  batch start; reloads pointers when in IDLE
- mem_cmd_vld  in  1  command valid, level, held by requester
- mem_cmd  in  4  0=LOAD_WEIGHTS, 1=LOAD_DATA, 3=WR_INFER_RES
- mem_cmd_data  in  32  word count N for loads; class word for writes
- mem_resp_vld  out  1  response valid, level
- mem_resp  out  3  0=WGHT_LOAD_DONE, 1=DATAVEC_LOAD_DONE, 2=WR_INFER_RES_DONE
- mem_resp_data  out  32  words transferred (loads); address written (writes)
- sram_req  out  1  SRAM request
- sram_gnt  in  1  request accepted this cycle
- sram_we  out  1  1=write, 0=read
- sram_addr  out  ADDR_WIDTH  word address
- sram_wdata  out  DATA_WIDTH  write data
- sram_rdata  in  DATA_WIDTH  read data
- sram_rvld  in  1  read data valid, in-order, any latency ≥1
- arr_wr_vld  out  1  array lane write strobe
- arr_wr_idx  out  $clog2(LANES)  lane index
- arr_wr_data  out  DATA_WIDTH  lane data
- arr_wghtbar_data  out  1  0=weight plane, 1=data plane; latched per load
- err  out  2  sticky; [0]=unsupported cmd, [1]=unexpected rvld; cleared by cfg_done in IDLE

Behaviour:
- Reset: async on rst_n low.
  - All outputs 0; state IDLE.
  - wght_ptr=WGHT_BASE, data_ptr=DATA_BASE, res_ptr=RES_BASE.
  - Counters 0. An in-flight transfer is abandoned.
- States: IDLE, RD, WR_RES, DONE.
- IDLE:
  - cfg_done → reload all three pointers; clear err.
  - Otherwise, mem_cmd_vld → latch cmd and data.
  - Load command: N = (data==0 ? 0 : min(data, LANES)). N=0 → DONE directly. Otherwise set arr_wghtbar_data (0 for weights, 1 for data) and go to RD.
  - cmd 3 → WR_RES.
  - Any other cmd: set err[0], stay IDLE, no response.
  - cfg_done has priority if it coincides with mem_cmd_vld; the command is accepted the next cycle.
- RD:
  - sram_req=1, we=0, addr = base_ptr + issued, while issued<N. Each gnt increments issued.
  - Each sram_rvld registers one array write: arr_wr_vld=1 next cycle, arr_wr_idx=returned, arr_wr_data=rdata; returned++.
  - Issue and return may occur in the same cycle.
  - When returned==N: advance wght_ptr or data_ptr by N, then go to DONE. arr_wr_vld for the last word is asserted in the first DONE cycle.
- WR_RES:
  - sram_req=1, we=1, addr=res_ptr, wdata=latched data.
  - On gnt: latch mem_resp_data=res_ptr, res_ptr++, wght_ptr←WGHT_BASE (weights reused per data point), go to DONE.
- DONE:
  - mem_resp_vld=1 with the code for the latched command, held steady.
  - Return to IDLE when mem_cmd_vld==0 or mem_cmd≠latched cmd. There is always one IDLE cycle before the next acceptance.
- Pointer arithmetic: ADDR_WIDTH wide, wraps modulo 2^ADDR_WIDTH without flagging.
- sram_rvld outside RD, or with returned==issued: ignored, err[1] set.
- cfg_done outside IDLE: ignored.
- mem_cmd changes while in RD or WR_RES: ignored until DONE.

Test Plan:
- cfg_done; LOAD_WEIGHTS N=32, gnt every cycle, read latency 2 → 32 reads at 0x0000..0x001F; arr_wr_idx 0..31 with data matching; mem_resp=0, mem_resp_data=32 held until cmd changes to 1; wght_ptr=0x0020.
- LOAD_DATA N=7, gnt toggling 1/0 → reads at 0x1000..0x1006; 7 array writes with arr_wghtbar_data=1; resp=1, data=7; a second LOAD_DATA N=7 reads 0x1007..0x100D.
- WR_INFER_RES data=1 with gnt delayed 3 cycles → one write of 1 to 0x8000; resp=2, data=0x8000; next LOAD_WEIGHTS starts at 0x0000.
- LOAD_WEIGHTS N=0 → no SRAM access; resp=0, data=0 within 2 cycles. N=40 → clamped to 32 transfers.
- mem_cmd=2 → err[0]=1, no response. Stray sram_rvld in IDLE → err[1]=1. cfg_done clears both.
- rst_n low mid-RD after 5 of 32 returns → all outputs 0 immediately; after release, LOAD_WEIGHTS reads from 0x0000 again.
